// File: rtl/yoda_filter_pkg.sv
// Shared types and helpers for the median-filter window tracker.
package yoda_filter_pkg;

  localparam int DEF_WINDOW_SIZE = 3;
  localparam int DEF_DATA_WIDTH  = 24;
  localparam int DEF_BUS_WIDTH   = 32;
  localparam int DEF_IMG_WIDTH   = 512;
  localparam int DEF_IMG_HEIGHT  = 512;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_FIN
  } tracker_state_e;

  // Number of valid window origins along one image dimension.
  function automatic int out_dim(input int img_dim, input int win);
    return img_dim - win + 1;
  endfunction

endpackage

// File: rtl/window_coord_counter.sv
// Raster-order (row, col) counter over the window-origin grid.
module window_coord_counter
  import yoda_filter_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int OUT_W     = 3,
  parameter int OUT_H     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 adv,
  output logic [BUS_WIDTH-1:0] row,
  output logic [BUS_WIDTH-1:0] col,
  output logic                 last
);

  localparam logic [BUS_WIDTH-1:0] COL_MAX = BUS_WIDTH'(OUT_W - 1);
  localparam logic [BUS_WIDTH-1:0] ROW_MAX = BUS_WIDTH'(OUT_H - 1);
  localparam logic [BUS_WIDTH-1:0] ONE     = BUS_WIDTH'(1);

  logic [BUS_WIDTH-1:0] row_q, row_d;
  logic [BUS_WIDTH-1:0] col_q, col_d;

  // Next coordinate: clear has priority, advance wraps the column into the next row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/window_index_tracker.sv
// Sweeps every window origin in raster order, handshakes each window with the
// median filter and forwards the returned pixel to the result memory.
module window_index_tracker
  import yoda_filter_pkg::*;
#(
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  Tracker_CLK,
  input  logic                  Tracker_RST,
  input  logic                  Tracker_START,
  output logic                  Tracker_BUSY,
  output logic                  Tracker_DONE,
  output logic                  Tracker_ERR,
  output logic                  Tracker_FEN,
  output logic [BUS_WIDTH-1:0]  Tracker_sROW,
  output logic [BUS_WIDTH-1:0]  Tracker_sCOL,
  input  logic [DATA_WIDTH-1:0] Tracker_FOUT,
  input  logic                  Tracker_FILTDRDY,
  output logic [BUS_WIDTH-1:0]  Tracker_WADDR,
  output logic [DATA_WIDTH-1:0] Tracker_WDATA,
  output logic                  Tracker_WVALID,
  input  logic                  Tracker_WREADY
);

  localparam int OUT_W = out_dim(IMG_WIDTH, WINDOW_SIZE);
  localparam int OUT_H = out_dim(IMG_HEIGHT, WINDOW_SIZE);
  localparam longint OUT_CNT = longint'(OUT_W) * longint'(OUT_H);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(1);
  localparam logic [BUS_WIDTH-1:0] OUT_W_B  = BUS_WIDTH'(OUT_W);

  // Reject parameter sets whose output grid is empty or cannot be addressed.
  if (OUT_W < 1 || OUT_H < 1) begin : g_chk_grid
    $error("window_index_tracker: window larger than image");
  end
  if (BUS_WIDTH < 63 && OUT_CNT > (longint'(1) << BUS_WIDTH)) begin : g_chk_addr
    $error("window_index_tracker: OUT_W*OUT_H does not fit BUS_WIDTH");
  end
  if (TIMEOUT_CYC < 1) begin : g_chk_tmo
    $error("window_index_tracker: TIMEOUT_CYC must be at least 1");
  end

  tracker_state_e        state_q, state_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  drdy_prev_q, drdy_prev_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  ctr_clr;
  logic                  ctr_adv;
  logic [BUS_WIDTH-1:0]  row;
  logic [BUS_WIDTH-1:0]  col;
  logic                  last;

  window_coord_counter #(
    .BUS_WIDTH(BUS_WIDTH),
    .OUT_W    (OUT_W),
    .OUT_H    (OUT_H)
  ) u_coord (
    .clk (Tracker_CLK),
    .rst (Tracker_RST),
    .clr (ctr_clr),
    .adv (ctr_adv),
    .row (row),
    .col (col),
    .last(last)
  );

  // Next-state logic; edge history is forced high in ISSUE so a level that is
  // already high when WAIT begins has to drop and rise again to count.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    drdy_prev_d = Tracker_FILTDRDY;
    wdata_d     = wdata_q;
    err_d       = err_q;
    ctr_clr     = 1'b0;
    ctr_adv     = 1'b0;
    accept      = (state_q == ST_WAIT) && Tracker_FILTDRDY && !drdy_prev_q;
    case (state_q)
      ST_IDLE: begin
        if (Tracker_START) begin
          err_d   = 1'b0;
          ctr_clr = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        tmo_d       = '0;
        drdy_prev_d = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (accept) begin
          wdata_d = Tracker_FOUT;
          state_d = ST_WRITE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          ctr_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ST_WRITE: begin
        if (Tracker_WREADY) begin
          if (last) begin
            state_d = ST_FIN;
          end else begin
            ctr_adv = 1'b1;
            state_d = ST_SETUP;
          end
        end
      end
      ST_FIN: begin
        ctr_clr = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, timeout counter, edge history, result data and error flag.
  always_ff @(posedge Tracker_CLK) begin
    if (Tracker_RST) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      drdy_prev_q <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      drdy_prev_q <= drdy_prev_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
    end
  end

  assign Tracker_BUSY   = (state_q != ST_IDLE);
  assign Tracker_DONE   = (state_q == ST_FIN);
  assign Tracker_ERR    = err_q;
  assign Tracker_FEN    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign Tracker_WVALID = (state_q == ST_WRITE);
  assign Tracker_sROW   = row;
  assign Tracker_sCOL   = col;
  assign Tracker_WADDR  = row * OUT_W_B + col;
  assign Tracker_WDATA  = wdata_q;

endmodule

// File: tb/tb_window_index_tracker.sv
// Directed bench for window_index_tracker on a 5x5 image with 3x3 windows.
module tb_window_index_tracker;

  localparam int WS = 3;
  localparam int DW = 24;
  localparam int BW = 32;
  localparam int IW = 5;
  localparam int IH = 5;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, wready;
  logic          busy, done, err, fen, wvalid;
  logic [BW-1:0] srow, scol, waddr;
  logic [DW-1:0] wdata;
  int            flt_mode;
  logic          man_drdy, mdl_drdy, drdy_in;
  logic [DW-1:0] man_fout, mdl_fout, fout_in;

  assign drdy_in = (flt_mode == 2) ? man_drdy : mdl_drdy;
  assign fout_in = (flt_mode == 2) ? man_fout : mdl_fout;

  window_index_tracker #(
    .WINDOW_SIZE(WS), .DATA_WIDTH(DW), .BUS_WIDTH(BW),
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .TIMEOUT_CYC(TO)
  ) dut (
    .Tracker_CLK     (clk),
    .Tracker_RST     (rst),
    .Tracker_START   (start),
    .Tracker_BUSY    (busy),
    .Tracker_DONE    (done),
    .Tracker_ERR     (err),
    .Tracker_FEN     (fen),
    .Tracker_sROW    (srow),
    .Tracker_sCOL    (scol),
    .Tracker_FOUT    (fout_in),
    .Tracker_FILTDRDY(drdy_in),
    .Tracker_WADDR   (waddr),
    .Tracker_WDATA   (wdata),
    .Tracker_WVALID  (wvalid),
    .Tracker_WREADY  (wready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] wr_addr [256];
  logic [DW-1:0] wr_data [256];
  logic [BW-1:0] rise_row[256];
  logic [BW-1:0] rise_col[256];
  int wr_cnt, done_cnt, rise_cnt, gap_bad;

  // Filter model: mode 0 answers row*10+col four cycles after a FEN rise, mode 1 never answers.
  initial begin
    int cnt;
    bit fen_prev;
    bit armed;
    logic [DW-1:0] val;
    mdl_drdy = 1'b0; mdl_fout = '0; fen_prev = 1'b0; armed = 1'b0; cnt = 0; val = '0;
    forever begin
      @(negedge clk);
      mdl_drdy = 1'b0;
      if (fen && !fen_prev && flt_mode == 0) begin
        armed = 1'b1;
        cnt = 0;
        val = DW'(srow * 10 + scol);
      end else if (armed) begin
        cnt++;
        if (cnt == 3) begin
          mdl_drdy = 1'b1;
          mdl_fout = val;
          armed = 1'b0;
        end
      end
      fen_prev = fen;
    end
  end

  // Recorder: accepted writes, DONE pulses, FEN rises with their coordinates.
  initial begin
    bit fen_prev;
    int low_run;
    wr_cnt = 0; done_cnt = 0; rise_cnt = 0; gap_bad = 0; fen_prev = 1'b0; low_run = 1;
    forever begin
      @(negedge clk);
      #4;
      if (wvalid && wready) begin
        if (wr_cnt < 256) begin
          wr_addr[wr_cnt] = waddr;
          wr_data[wr_cnt] = wdata;
        end
        wr_cnt++;
      end
      if (done) done_cnt++;
      if (fen && !fen_prev) begin
        if (rise_cnt < 256) begin
          rise_row[rise_cnt] = srow;
          rise_col[rise_cnt] = scol;
        end
        if (low_run < 1) gap_bad++;
        rise_cnt++;
      end
      low_run  = fen ? 0 : low_run + 1;
      fen_prev = fen;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic wait_writes(input int target, input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (wr_cnt >= target) seen = 1'b1;
    end
  endtask

  task automatic wait_wvalid(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (wvalid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wready = 1'b0; flt_mode = 1; man_drdy = 1'b0; man_fout = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (fen !== 1'b0)    begin n_fail++; $display("FAIL reset_fen: got %0h want 0", fen); end
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
    n_tests++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %0h want 0", done); end
    n_tests++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %0h want 0", err); end
    n_tests++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %0h want 0", wvalid); end
    n_tests++; if (srow !== '0)     begin n_fail++; $display("FAIL reset_srow: got %0h want 0", srow); end
    n_tests++; if (scol !== '0)     begin n_fail++; $display("FAIL reset_scol: got %0h want 0", scol); end
    n_tests++; if (waddr !== '0)    begin n_fail++; $display("FAIL reset_waddr: got %0h want 0", waddr); end
    n_tests++; if (wdata !== '0)    begin n_fail++; $display("FAIL reset_wdata: got %0h want 0", wdata); end
  endtask

  task automatic test_sweep();
    int b_wr, b_done, b_rise, b_gap;
    bit seen;
    flt_mode = 0; wready = 1'b1;
    b_wr = wr_cnt; b_done = done_cnt; b_rise = rise_cnt; b_gap = gap_bad;
    pulse_start();
    wait_done(400, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL sweep_done_seen: got %0d want 1", seen); end
    repeat (3) @(negedge clk);
    n_tests++; if (wr_cnt - b_wr !== 9) begin n_fail++; $display("FAIL sweep_wr_count: got %0d want 9", wr_cnt - b_wr); end
    for (int k = 0; k < 9; k++) begin
      n_tests++;
      if (wr_addr[b_wr+k] !== BW'(k)) begin
        n_fail++; $display("FAIL sweep_addr[%0d]: got %0d want %0d", k, wr_addr[b_wr+k], k);
      end
      n_tests++;
      if (wr_data[b_wr+k] !== DW'((k / 3) * 10 + (k % 3))) begin
        n_fail++; $display("FAIL sweep_data[%0d]: got %0d want %0d", k, wr_data[b_wr+k], (k / 3) * 10 + (k % 3));
      end
      n_tests++;
      if (rise_row[b_rise+k] !== BW'(k / 3) || rise_col[b_rise+k] !== BW'(k % 3)) begin
        n_fail++; $display("FAIL sweep_fen_coord[%0d]: got (%0d,%0d) want (%0d,%0d)", k,
                           rise_row[b_rise+k], rise_col[b_rise+k], k / 3, k % 3);
      end
    end
    n_tests++; if (done_cnt - b_done !== 1) begin n_fail++; $display("FAIL sweep_done_pulses: got %0d want 1", done_cnt - b_done); end
    n_tests++; if (rise_cnt - b_rise !== 9) begin n_fail++; $display("FAIL sweep_fen_rises: got %0d want 9", rise_cnt - b_rise); end
    n_tests++; if (gap_bad !== b_gap) begin n_fail++; $display("FAIL sweep_fen_gap: got %0d short gaps want 0", gap_bad - b_gap); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sweep_busy_after: got %0h want 0", busy); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL sweep_err: got %0h want 0", err); end
  endtask

  task automatic test_wready_stall();
    int b_wr, b_rise, rises;
    bit seen;
    flt_mode = 0; wready = 1'b1;
    b_wr = wr_cnt; b_rise = rise_cnt;
    pulse_start();
    wait_writes(b_wr + 3, 200, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stall_reach_w4: got %0d want 1", seen); end
    wready = 1'b0;
    wait_wvalid(50, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stall_wvalid_seen: got %0d want 1", seen); end
    rises = rise_cnt;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      n_tests++; if (wvalid !== 1'b1) begin n_fail++; $display("FAIL stall_wvalid[%0d]: got %0h want 1", c, wvalid); end
      n_tests++; if (waddr !== BW'(3)) begin n_fail++; $display("FAIL stall_waddr[%0d]: got %0d want 3", c, waddr); end
      n_tests++; if (wdata !== DW'(10)) begin n_fail++; $display("FAIL stall_wdata[%0d]: got %0d want 10", c, wdata); end
    end
    n_tests++; if (rise_cnt !== rises) begin n_fail++; $display("FAIL stall_no_fen: got %0d rises want %0d", rise_cnt, rises); end
    wready = 1'b1;
    wait_done(400, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stall_done_seen: got %0d want 1", seen); end
    repeat (2) @(negedge clk);
    n_tests++; if (wr_cnt - b_wr !== 9) begin n_fail++; $display("FAIL stall_wr_count: got %0d want 9", wr_cnt - b_wr); end
    n_tests++; if (wr_data[b_wr+3] !== DW'(10)) begin n_fail++; $display("FAIL stall_w4_data: got %0d want 10", wr_data[b_wr+3]); end
    n_tests++; if (rise_cnt - b_rise !== 9) begin n_fail++; $display("FAIL stall_fen_rises: got %0d want 9", rise_cnt - b_rise); end
  endtask

  task automatic test_stuck_drdy();
    int b_wr;
    bit seen;
    flt_mode = 2; man_drdy = 1'b0; man_fout = '0; wready = 1'b1;
    b_wr = wr_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (fen) seen = 1'b1; else @(negedge clk);
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stuck_fen_seen: got %0d want 1", seen); end
    man_drdy = 1'b1; man_fout = 24'h0BAD00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL stuck_no_accept[%0d]: got %0h want 0", c, wvalid); end
      n_tests++; if (fen !== 1'b1) begin n_fail++; $display("FAIL stuck_fen_held[%0d]: got %0h want 1", c, fen); end
    end
    man_drdy = 1'b0;
    @(negedge clk);
    man_drdy = 1'b1; man_fout = 24'h123456;
    @(negedge clk);
    man_drdy = 1'b0;
    flt_mode = 0;
    n_tests++; if (wvalid !== 1'b1) begin n_fail++; $display("FAIL stuck_accept_wvalid: got %0h want 1", wvalid); end
    n_tests++; if (wdata !== 24'h123456) begin n_fail++; $display("FAIL stuck_accept_wdata: got %0h want 123456", wdata); end
    n_tests++; if (waddr !== '0) begin n_fail++; $display("FAIL stuck_accept_waddr: got %0d want 0", waddr); end
    wait_done(400, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stuck_done_seen: got %0d want 1", seen); end
    repeat (2) @(negedge clk);
    n_tests++; if (wr_cnt - b_wr !== 9) begin n_fail++; $display("FAIL stuck_wr_count: got %0d want 9", wr_cnt - b_wr); end
    n_tests++; if (wr_data[b_wr] !== 24'h123456) begin n_fail++; $display("FAIL stuck_w0_data: got %0h want 123456", wr_data[b_wr]); end
    n_tests++; if (wr_data[b_wr+1] !== DW'(1)) begin n_fail++; $display("FAIL stuck_w1_data: got %0d want 1", wr_data[b_wr+1]); end
  endtask

  task automatic test_timeout();
    int b_wr, b_done, hi;
    bit seen;
    flt_mode = 1; wready = 1'b1;
    b_wr = wr_cnt; b_done = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (fen) seen = 1'b1; else @(negedge clk);
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL tmo_fen_seen: got %0d want 1", seen); end
    hi = 0;
    while (fen && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    n_tests++; if (hi !== 17) begin n_fail++; $display("FAIL tmo_fen_cycles: got %0d want 17", hi); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %0h want 1", err); end
    n_tests++; if (fen !== 1'b0) begin n_fail++; $display("FAIL tmo_fen: got %0h want 0", fen); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %0h want 0", busy); end
    repeat (3) @(negedge clk);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %0h want 1", err); end
    n_tests++; if (done_cnt - b_done !== 0) begin n_fail++; $display("FAIL tmo_no_done: got %0d want 0", done_cnt - b_done); end
    n_tests++; if (wr_cnt - b_wr !== 0) begin n_fail++; $display("FAIL tmo_no_write: got %0d want 0", wr_cnt - b_wr); end
    flt_mode = 0;
    pulse_start();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_restart_err: got %0h want 0", err); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_restart_busy: got %0h want 1", busy); end
    n_tests++; if (srow !== '0 || scol !== '0) begin n_fail++; $display("FAIL tmo_restart_coord: got (%0d,%0d) want (0,0)", srow, scol); end
    wait_done(400, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL tmo_restart_done: got %0d want 1", seen); end
    repeat (2) @(negedge clk);
    n_tests++; if (wr_cnt - b_wr !== 9) begin n_fail++; $display("FAIL tmo_restart_writes: got %0d want 9", wr_cnt - b_wr); end
    n_tests++; if (wr_addr[b_wr] !== '0) begin n_fail++; $display("FAIL tmo_restart_addr0: got %0d want 0", wr_addr[b_wr]); end
  endtask

  task automatic test_reset_midsweep();
    int b_wr;
    bit seen;
    flt_mode = 0; wready = 1'b1;
    b_wr = wr_cnt;
    pulse_start();
    wait_writes(b_wr + 5, 300, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_w6: got %0d want 1", seen); end
    wready = 1'b0;
    wait_wvalid(50, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_wvalid_seen: got %0d want 1", seen); end
    n_tests++; if (srow !== BW'(1) || scol !== BW'(2)) begin n_fail++; $display("FAIL rstmid_coord: got (%0d,%0d) want (1,2)", srow, scol); end
    n_tests++; if (waddr !== BW'(5)) begin n_fail++; $display("FAIL rstmid_waddr: got %0d want 5", waddr); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || fen !== 1'b0 || done !== 1'b0 || err !== 1'b0 || wvalid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got busy=%0h fen=%0h done=%0h err=%0h wvalid=%0h want all 0", busy, fen, done, err, wvalid);
    end
    n_tests++; if (srow !== '0 || scol !== '0) begin n_fail++; $display("FAIL rstmid_coord0: got (%0d,%0d) want (0,0)", srow, scol); end
    n_tests++; if (waddr !== '0) begin n_fail++; $display("FAIL rstmid_waddr0: got %0d want 0", waddr); end
    n_tests++; if (wdata !== '0) begin n_fail++; $display("FAIL rstmid_wdata0: got %0d want 0", wdata); end
    rst = 1'b0; wready = 1'b1;
    pulse_start();
    wait_done(400, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_done_seen: got %0d want 1", seen); end
    repeat (2) @(negedge clk);
    n_tests++; if (wr_cnt - b_wr !== 14) begin n_fail++; $display("FAIL rstmid_writes: got %0d want 14", wr_cnt - b_wr); end
    n_tests++; if (wr_addr[b_wr+5] !== '0 || wr_data[b_wr+5] !== '0) begin
      n_fail++; $display("FAIL rstmid_first: got addr %0d data %0d want 0 0", wr_addr[b_wr+5], wr_data[b_wr+5]);
    end
    n_tests++; if (wr_addr[b_wr+13] !== BW'(8) || wr_data[b_wr+13] !== DW'(22)) begin
      n_fail++; $display("FAIL rstmid_last: got addr %0d data %0d want 8 22", wr_addr[b_wr+13], wr_data[b_wr+13]);
    end
  endtask

  task automatic test_back_to_back();
    int b_wr, b_done, b_rise;
    bit seen;
    flt_mode = 0; wready = 1'b1;
    b_wr = wr_cnt; b_done = done_cnt; b_rise = rise_cnt;
    pulse_start();
    repeat (10) @(negedge clk);
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_done(400, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL b2b_done_seen: got %0d want 1", seen); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++; if (done_cnt - b_done !== 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt - b_done); end
    n_tests++; if (wr_cnt - b_wr !== 9) begin n_fail++; $display("FAIL b2b_writes: got %0d want 9", wr_cnt - b_wr); end
    n_tests++; if (rise_cnt - b_rise !== 9) begin n_fail++; $display("FAIL b2b_fen_rises: got %0d want 9", rise_cnt - b_rise); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %0h want 0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wready = 1'b0; flt_mode = 1; man_drdy = 1'b0; man_fout = '0;
    test_reset();
    test_sweep();
    test_wready_stall();
    test_stuck_drdy();
    test_timeout();
    test_reset_midsweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
